// File: rtl/draw_sprite.sv
// draw_sprite: overlays a ROM-backed sprite on a pixel stream.
// Position, scale and enable are shadowed at each vsync rising edge, so changes
// made mid-frame take effect on the next frame. The sprite area is one sprite
// (2^SPR_W_LOG2 x 2^SPR_H_LOG2 source pixels) at 1x or 2x pixel replication.
// The timing path is delayed ROM_LAT+2 cycles so that it stays aligned with
// the data coming back from the external sprite memory.
// Optional feature: define DRAW_SPRITE_MIRROR_EN to add a horizontal-mirror input.
module draw_sprite #(
   parameter int          SPR_W_LOG2 = 6,
   parameter int          SPR_H_LOG2 = 6,
   parameter int          ROM_LAT    = 1,
   parameter logic [11:0] KEY_COLOR  = 12'hfff
) (
   input  logic                             pclk,
   input  logic                             rst,
   input  logic [10:0]                      hcount_in,
   input  logic [10:0]                      vcount_in,
   input  logic                             hsync_in,
   input  logic                             vsync_in,
   input  logic                             hblnk_in,
   input  logic                             vblnk_in,
   input  logic [11:0]                      rgb_in,
   input  logic [11:0]                      xpos,
   input  logic [11:0]                      ypos,
   input  logic                             scale,
   input  logic                             enable,
`ifdef DRAW_SPRITE_MIRROR_EN
   input  logic                             mirror,
`endif
   input  logic [11:0]                      rgb_pixel,
   output logic [SPR_W_LOG2+SPR_H_LOG2-1:0] pixel_addr,
   output logic [10:0]                      hcount_out,
   output logic [10:0]                      vcount_out,
   output logic                             hsync_out,
   output logic                             vsync_out,
   output logic                             hblnk_out,
   output logic                             vblnk_out,
   output logic [11:0]                      rgb_out
);

   localparam int AW  = SPR_W_LOG2 + SPR_H_LOG2;
   localparam int DLY = ROM_LAT + 2;  // total delay of the timing path
   localparam int TW  = 26;           // packed {hcount, vcount, hsync, vsync, hblnk, vblnk}

   // Shadow copies of the frame-level controls.
   logic [11:0] xs_q, ys_q;
   logic        scale_q, en_q, mirror_q;
   logic        vsync_prev_q;
   logic        shadow_load;

   assign shadow_load = vsync_in & ~vsync_prev_q;

   // Capture frame controls on the vsync rising edge only.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         xs_q         <= '0;
         ys_q         <= '0;
         scale_q      <= 1'b0;
         en_q         <= 1'b0;
         mirror_q     <= 1'b0;
         vsync_prev_q <= 1'b0;
      end else begin
         vsync_prev_q <= vsync_in;
         if (shadow_load) begin
            xs_q    <= xpos;
            ys_q    <= ypos;
            scale_q <= scale;
            en_q    <= enable;
`ifdef DRAW_SPRITE_MIRROR_EN
            mirror_q <= mirror;
`else
            mirror_q <= 1'b0;
`endif
         end
      end
   end

   // Hit test and address generation for the incoming pixel. Region bounds are
   // kept at 13 bits so a sprite near the right/bottom edge never wraps.
   logic [12:0]           spr_w, spr_h, x_end, y_end;
   logic [11:0]           dx, dy;
   logic [SPR_W_LOG2-1:0] col, col_m;
   logic [SPR_H_LOG2-1:0] row;
   logic                  hit_d;
   logic [AW-1:0]         addr_d;

   // Combinational region test and {row, column} address.
   always_comb begin
      spr_w  = 13'(2 ** SPR_W_LOG2);
      spr_h  = 13'(2 ** SPR_H_LOG2);
      if (scale_q) begin
         spr_w = spr_w << 1;
         spr_h = spr_h << 1;
      end
      x_end  = {1'b0, xs_q} + spr_w;
      y_end  = {1'b0, ys_q} + spr_h;
      hit_d  = en_q && !hblnk_in && !vblnk_in &&
               ({2'b00, hcount_in} >= {1'b0, xs_q}) && ({2'b00, hcount_in} < x_end) &&
               ({2'b00, vcount_in} >= {1'b0, ys_q}) && ({2'b00, vcount_in} < y_end);
      dx     = {1'b0, hcount_in} - xs_q;
      dy     = {1'b0, vcount_in} - ys_q;
      col    = SPR_W_LOG2'(dx >> scale_q);
      row    = SPR_H_LOG2'(dy >> scale_q);
      col_m  = mirror_q ? ~col : col;
      addr_d = hit_d ? {row, col_m} : '0;
   end

   // Delay lines: timing/background/hit travel together so the hit flag is
   // never recomputed on delayed counters.
   logic [TW-1:0]   tim_q [DLY];
   logic [11:0]     rgb_q [DLY-1];
   logic            hit_q [DLY-1];
   logic [AW-1:0]   addr_q;
   logic [11:0]     rgb_out_q;

   // Register the address and shift the pipeline; rgb compositing happens in
   // the final stage, when the memory data for this pixel is present.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         addr_q    <= '0;
         rgb_out_q <= '0;
         for (int i = 0; i < DLY; i++) tim_q[i] <= '0;
         for (int i = 0; i < DLY - 1; i++) begin
            rgb_q[i] <= '0;
            hit_q[i] <= 1'b0;
         end
      end else begin
         addr_q   <= addr_d;
         tim_q[0] <= {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
         rgb_q[0] <= rgb_in;
         hit_q[0] <= hit_d;
         for (int i = 1; i < DLY; i++) tim_q[i] <= tim_q[i-1];
         for (int i = 1; i < DLY - 1; i++) begin
            rgb_q[i] <= rgb_q[i-1];
            hit_q[i] <= hit_q[i-1];
         end
         rgb_out_q <= (hit_q[DLY-2] && (rgb_pixel != KEY_COLOR)) ? rgb_pixel : rgb_q[DLY-2];
      end
   end

   assign pixel_addr = addr_q;
   assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = tim_q[DLY-1];
   assign rgb_out    = rgb_out_q;

endmodule
